// File: rtl/dco_arr_pkg.sv
// dco_arr_pkg: shared constants and code type for the 5x5 DCO capacitor array
package dco_arr_pkg;
  localparam int SIZE = 5;
  localparam int MAX = 25;
  localparam int CNT_W = 8;
  localparam logic [4:0] RST_WORD = 5'd13;
  localparam logic [4:0] R_ALL_RST = 5'd28;
  localparam logic [4:0] ROW_RST = 5'd4;
  localparam logic [4:0] COL_RST = 5'd7;
  typedef struct packed {
    logic [4:0] r_all;
    logic [4:0] row;
    logic [4:0] col;
  } arr_code_t;
endpackage

// File: rtl/row_col_dec_5x5_if.sv
// row_col_dec_5x5_if: sample input, ready/valid output and status bundle of the decoder
interface row_col_dec_5x5_if;
  logic in_vld;
  logic [4:0] r_all;
  logic [4:0] row;
  logic [4:0] col;
  logic out_rdy;
  logic clr;
  logic out_vld;
  logic [4:0] out_word;
  logic out_err;
  logic err_sticky;
  logic [dco_arr_pkg::CNT_W-1:0] err_cnt;
  logic ovf;
  modport master (
    output in_vld, r_all, row, col, out_rdy, clr,
    input out_vld, out_word, out_err, err_sticky, err_cnt, ovf
  );
  modport slave (
    input in_vld, r_all, row, col, out_rdy, clr,
    output out_vld, out_word, out_err, err_sticky, err_cnt, ovf
  );
endinterface

// File: rtl/row_col_chk_5x5.sv
// row_col_chk_5x5: combinational legality check and word recovery for one array code
module row_col_chk_5x5
  import dco_arr_pkg::*;
(
  input  arr_code_t  code,
  output logic [4:0] word,
  output logic       legal
);
  localparam logic [4:0] ONES = 5'h1f;
  logic [2:0] k;
  logic [2:0] n;
  logic [4:0] therm;
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < SIZE; i++) if (code.row[i]) k = 3'(i);
    n = 3'($countones(code.col));
    // odd rows fill from the MSB end, even rows from the LSB end (serpentine fill)
    therm = k[0] ? ONES << (3'd5 - n) : ~(ONES << n);
    legal = $onehot(code.row) && code.r_all == (ONES << k) && code.col == therm &&
            (k == 3'd0 || n != 3'd0);
    word = 5'({2'b00, k} * 5'd5 + {2'b00, n});
  end
endmodule

// File: rtl/row_col_dec_5x5.sv
// row_col_dec_5x5: two-stage pipelined decoder of the 5x5 row/col array code with error stats
module row_col_dec_5x5
  import dco_arr_pkg::*;
(
  input logic clk,
  input logic rst,
  row_col_dec_5x5_if.slave bus
);
  arr_code_t code;
  logic [4:0] word, last_good, s1_word, out_word;
  logic legal, s1_vld, s1_err, out_vld, out_err, err_sticky, ovf, adv, acc;
  logic [CNT_W-1:0] err_cnt;
  assign code = {bus.r_all, bus.row, bus.col};
  row_col_chk_5x5 u_chk (.code(code), .word(word), .legal(legal));
  assign adv = s1_vld && (!out_vld || bus.out_rdy);
  assign acc = bus.in_vld && (!s1_vld || adv);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_word <= RST_WORD;
      s1_err <= 1'b0;
      last_good <= RST_WORD;
      out_vld <= 1'b0;
      out_word <= RST_WORD;
      out_err <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (acc) begin
        s1_word <= legal ? word : last_good;
        s1_err <= !legal;
        if (legal) last_good <= word;
      end
      s1_vld <= acc || (s1_vld && !adv);
      if (adv) begin
        out_word <= s1_word;
        out_err <= s1_err;
      end
      out_vld <= adv || (out_vld && !bus.out_rdy);
      err_sticky <= !bus.clr && (err_sticky || (adv && s1_err));
      err_cnt <= bus.clr ? '0 : (adv && s1_err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      // a drop in the same cycle as clr must still be reported
      ovf <= (bus.in_vld && !acc) || (ovf && !bus.clr);
    end
  end
  assign bus.out_vld = out_vld;
  assign bus.out_word = out_word;
  assign bus.out_err = out_err;
  assign bus.err_sticky = err_sticky;
  assign bus.err_cnt = err_cnt;
  assign bus.ovf = ovf;
endmodule
